// File: rtl/mul_accumulator.sv
// mul_accumulator
//
// Accumulation stage for the multiply-accumulate path. Consumes a stream of
// 2N-bit unsigned products from the upstream multiplier and sums them into an
// ACC_W-bit accumulator. A beat tagged with in_last closes the sequence. The
// final sum, saturating term count and sticky overflow flag are then held
// until the consumer takes them.
//
// Parameters
//   N      operand width of the upstream multiplier (product width is 2N)
//   ACC_W  accumulator width, must be >= 2N
//   CNT_W  term-counter width
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous abort; discards the sequence in progress
//   in_valid   prod carries a valid product
//   in_ready   block accepts a beat this cycle (decode of state only)
//   prod       unsigned product, 2N bits
//   in_last    final term of the current sequence
//   out_valid  result is held and valid
//   out_ready  consumer accepts the result
//   acc_out    accumulated sum, modulo 2^ACC_W
//   cnt_out    number of accepted terms, saturating at 2^CNT_W-1
//   ovf        sticky: the sum exceeded 2^ACC_W-1 during the sequence
module mul_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*N-1:0]     prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]   cnt_out,
    output logic               ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;

    // One extra bit on top of the accumulator captures the carry out of
    // bit ACC_W-1, which is what feeds the sticky overflow flag.
    logic [ACC_W:0]     sum;
    logic               accept;

    assign sum    = {1'b0, acc_reg} + {{(ACC_W + 1 - 2*N){1'b0}}, prod};
    assign accept = in_valid & in_ready;

    // in_ready deliberately ignores clr: a beat presented during clr looks
    // accepted upstream but is dropped by the clr branch below.
    assign in_ready  = (state_reg == ACC);
    assign out_valid = (state_reg == DONE);
    assign acc_out   = acc_reg;
    assign cnt_out   = cnt_reg;
    assign ovf       = ovf_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;

        if (clr) begin
            // Abort wins over any beat, in_last or output handshake.
            state_next = ACC;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        acc_next = sum[ACC_W-1:0];
                        ovf_next = ovf_reg | sum[ACC_W];
                        if (cnt_reg != CNT_MAX) begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                        if (in_last) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it; the
                    // clear happens on the handshake edge so the next
                    // sequence starts from zero.
                    if (out_ready) begin
                        state_next = ACC;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ACC;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

endmodule

// File: doc/mul_accumulator.md
# mul_accumulator

Sequential accumulation stage that sits directly downstream of the combinational `multiplier`. It consumes a stream of 2N-bit unsigned products under a valid/ready handshake and sums them into a wider accumulator. It closes each sequence on a `last`-tagged beat and holds the final sum, term count and sticky overflow flag until the consumer accepts them. Together with `multiplier`, this block forms the ALU's multiply-accumulate path.

## Interface
- `N`, 4, operand width of the upstream multiplier; product width is 2N.
- `ACC_W`, 12, accumulator width; must be ≥ 2N.
- `CNT_W`, 4, term-counter width.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous abort; discards the sequence in progress.
- `in_valid`  in  1  `prod` holds a valid product.
- `in_ready`  out  1  block accepts a beat this cycle.
- `prod`  in  2N  unsigned product from `multiplier`.
- `in_last`  in  1  final term of the current sequence.
- `out_valid`  out  1  result is held and valid.
- `out_ready`  in  1  consumer accepts the result.
- `acc_out`  out  ACC_W  accumulated sum.
- `cnt_out`  out  CNT_W  number of terms accepted, saturating.
- `ovf`  out  1  sticky flag: the sum exceeded 2^ACC_W − 1 during the sequence.

## Operation
- The FSM has two states:
  - **ACC** (reset state): `in_ready`=1, `out_valid`=0.
  - **DONE**: `in_ready`=0, `out_valid`=1.
- A beat is accepted when `in_valid & in_ready`.
- On an accepted beat in ACC:
  - `acc` ← (`acc` + zero-extended `prod`) mod 2^ACC_W.
  - `ovf` ← `ovf` | carry out of bit ACC_W−1.
  - `cnt` ← `cnt`+1, saturating at 2^CNT_W − 1.
- If the accepted beat has `in_last`=1, the sum and count above include that beat and the next state is DONE.
- In DONE, `acc_out`, `cnt_out` and `ovf` are stable.
- On `out_valid & out_ready` in DONE: `acc`, `cnt` and `ovf` clear to 0, and the next state is ACC.
- `clr`=1, in any state:
  - `acc`, `cnt`, `ovf` ← 0 and state ← ACC.
  - `clr` overrides a simultaneous accepted beat, `in_last`, or output handshake; that beat is dropped.
  - Because `in_ready` is combinational from state, `in_ready` can be 1 while `clr`=1, but the beat is still discarded.
- `in_valid` while in DONE: the beat is not accepted, and upstream must hold it.
- `prod`=0 accepted: it counts as a term, and `acc` is unchanged.
- `in_last` with `in_valid`=0 is ignored.
- Once overflow occurs, `ovf` stays 1 until the output handshake, `clr`, or `rst`. Wrapped `acc` keeps accumulating modulo 2^ACC_W.

## Timing
- `rst` asserted takes effect immediately, independent of `clk`:
  - State = ACC.
  - `acc_out`=0, `cnt_out`=0, `ovf`=0, `out_valid`=0.
  - `in_ready` reflects ACC, so it goes to 1 without a clock edge.
- Reset mid-sequence or mid-DONE discards everything; no result is emitted.
- `in_ready` is a combinational decode of state only; it does not depend on `in_valid` or `out_ready`.
- `acc_out`, `cnt_out`, `ovf` and `out_valid` are registered.
- Throughput and latency:
  - Throughput is 1 term per cycle in ACC.
  - Latency is 1 cycle: `out_valid` rises at the edge that accepts the `in_last` beat.
- Minimum DONE residency is 1 cycle, so there is a 1-cycle bubble between back-to-back sequences when `out_ready` is held high.
- `out_valid` stays high and outputs stay stable until a handshake or `clr`. The consumer may stall indefinitely.
- A sequence of K terms occupies K cycles in ACC plus at least 1 cycle in DONE.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → outputs 0 and `in_ready`=1 without a clock edge; `out_valid`=0 after release.
- **Basic sum:** products 18, 81, 75 on consecutive cycles, `in_last` on 75, `out_ready`=1 → `out_valid` for 1 cycle with `acc_out`=174, `cnt_out`=3, `ovf`=0; `in_ready` returns to 1 the next cycle.
- **Overflow (ACC_W=8):** products 225 then 225 with `in_last` → `acc_out`=194, `ovf`=1, `cnt_out`=2. A following sequence of a single `prod`=5 → `acc_out`=5, `ovf`=0.
- **Back-pressure:** `out_ready`=0 for 5 cycles after DONE while `in_valid`=1 with `prod`=9 → `in_ready`=0 and outputs frozen throughout. Raising `out_ready` → handshake, then `prod`=9 accepted the following cycle.
- **Abort:** accept 2 beats (prod 3, 4), then `clr` together with an accepted `in_last` beat (prod 7) → state ACC, `acc`=0, `out_valid` never asserts. A next sequence of `prod`=6 alone → `acc_out`=6.
- **Count saturation (CNT_W=2):** 5 beats of `prod`=1 with `in_last` on the 5th → `cnt_out`=3, `acc_out`=5, `ovf`=0.
